// File: rtl/pipeline_ready_reg_if.sv
// rtl/pipeline_ready_reg_if.sv - valid/ready handshake bundle for the backward-path register slice
interface pipeline_ready_reg_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  // Slice side: consumes the upstream beat and the downstream ready.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

  // Environment side: drives upstream beats and downstream ready.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );
endinterface

// File: rtl/pipeline_ready_reg.sv
// rtl/pipeline_ready_reg.sv - registered-ready slice with one skid entry and a saturating capture counter
module pipeline_ready_reg #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_ready_reg_if.slave  bus,
  output logic                 skid_full,
  output logic [CNT_WIDTH-1:0] skid_count,
  input  logic                 clr_count
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_EMPTY = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e                state_q;
  logic                  in_ready_q;
  logic                  skid_valid_q;
  logic [DATA_WIDTH-1:0] skid_data_q;
  logic [CNT_WIDTH-1:0]  skid_count_q;
  logic [CNT_WIDTH-1:0]  skid_count_d;
  logic                  capture;

  // A beat is parked only when it is accepted while downstream is stalled.
  always_comb begin
    capture      = (state_q == ST_EMPTY) && bus.in_valid && !bus.out_ready;
    skid_count_d = skid_count_q;
    if (clr_count) begin
      skid_count_d = '0;
    end else if (capture && !(&skid_count_q)) begin
      skid_count_d = skid_count_q + CNT_WIDTH'(1);
    end
  end

  // Control FSM; ready and skid-valid are registered so in_ready never sees out_ready combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_INIT;
      in_ready_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_count_q <= '0;
    end else begin
      skid_count_q <= skid_count_d;
      case (state_q)
        ST_INIT: begin
          state_q      <= ST_EMPTY;
          in_ready_q   <= 1'b1;
          skid_valid_q <= 1'b0;
        end
        ST_EMPTY: begin
          if (capture) begin
            state_q      <= ST_FULL;
            in_ready_q   <= 1'b0;
            skid_valid_q <= 1'b1;
          end
        end
        ST_FULL: begin
          if (bus.out_ready) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b1;
            skid_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= ST_INIT;
          in_ready_q   <= 1'b0;
          skid_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Skid payload needs no reset: it is only observed while skid_valid_q is set.
  always_ff @(posedge clk) begin
    if (capture) begin
      skid_data_q <= bus.in_data;
    end
  end

  // Skid beat always wins over the live input so ordering is preserved.
  always_comb begin
    bus.in_ready  = in_ready_q;
    bus.out_valid = skid_valid_q | (bus.in_valid & in_ready_q);
    bus.out_data  = skid_valid_q ? skid_data_q : bus.in_data;
    skid_full     = skid_valid_q;
    skid_count    = skid_count_q;
  end

endmodule

// File: tb/tb_pipeline_ready_reg.sv
// tb/tb_pipeline_ready_reg.sv - scoreboard bench for pipeline_ready_reg
module tb_pipeline_ready_reg;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          clr_count;
  logic          skid_full;
  logic [CW-1:0] skid_count;

  pipeline_ready_reg_if #(.DATA_WIDTH(DW)) bus_if ();

  pipeline_ready_reg #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus_if),
    .skid_full  (skid_full),
    .skid_count (skid_count),
    .clr_count  (clr_count)
  );

  int            n_cmp  = 0;
  int            n_fail = 0;
  logic [DW-1:0] exp_q[$];
  bit            chk_en = 1'b0;
  bit            rnd_done = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Hold a beat until the slice accepts it; record the expected output on acceptance.
  task automatic send(input logic [DW-1:0] d);
    bit ok;
    ok = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.in_data  = d;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (bus_if.in_ready) begin
        exp_q.push_back(d);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got no acceptance expected acceptance of 0x%0h", d);
    end
    @(posedge clk);
    #2;
    bus_if.in_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every downstream transfer, and checks stall stability.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] data_prev  = '0;
  always begin
    @(negedge clk);
    #1;
    if (rst_n && bus_if.out_valid && bus_if.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_beat: got 0x%0h expected no beat", bus_if.out_data);
      end else begin
        check("out_data", bus_if.out_data, exp_q.pop_front());
      end
    end
    if (chk_en && stall_prev) begin
      check("stall_out_valid", {31'b0, bus_if.out_valid}, 32'd1);
      check("stall_out_data", bus_if.out_data, data_prev);
    end
    stall_prev = bus_if.out_valid && !bus_if.out_ready;
    data_prev  = bus_if.out_data;
  end

  // in_ready must not move when inputs change mid-cycle.
  logic rdy_early;
  always begin
    @(posedge clk);
    #1;
    rdy_early = bus_if.in_ready;
    @(negedge clk);
    if (chk_en) check("in_ready_mid_cycle", {31'b0, bus_if.in_ready}, {31'b0, rdy_early});
  end

  initial begin
    time t0;
    rst_n            = 1'b0;
    clr_count        = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.in_data   = 32'hA5A5_A5A5;
    bus_if.out_ready = 1'b1;

    // Reset state with in_valid held high.
    tick();
    check("rst_in_ready", {31'b0, bus_if.in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, bus_if.out_valid}, 32'd0);
    check("rst_skid_full", {31'b0, skid_full}, 32'd0);
    check("rst_skid_count", {28'b0, skid_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("init_in_ready", {31'b0, bus_if.in_ready}, 32'd0);
    check("init_out_valid", {31'b0, bus_if.out_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("c2_in_ready", {31'b0, bus_if.in_ready}, 32'd1);
    check("c2_out_valid", {31'b0, bus_if.out_valid}, 32'd1);
    check("c2_out_data", bus_if.out_data, 32'hA5A5_A5A5);
    send(32'hA5A5_A5A5);

    // Back-to-back streaming at one beat per cycle.
    t0 = $time;
    for (int i = 0; i < 8; i++) send(32'(i));
    check("stream_cycles", 32'(($time - t0) / 10), 32'd8);
    check("stream_skid_count", {28'b0, skid_count}, 32'd0);

    // Single stall with three held cycles.
    bus_if.out_ready = 1'b0;
    send(32'h11);
    check("stall_skid_full", {31'b0, skid_full}, 32'd1);
    check("stall_in_ready", {31'b0, bus_if.in_ready}, 32'd0);
    check("stall_data0", bus_if.out_data, 32'h11);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_hold_data", bus_if.out_data, 32'h11);
      check("stall_hold_valid", {31'b0, bus_if.out_valid}, 32'd1);
    end
    tick();
    bus_if.out_ready = 1'b1;
    @(negedge clk);
    check("drain_bubble_in_ready", {31'b0, bus_if.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("post_drain_in_ready", {31'b0, bus_if.in_ready}, 32'd1);
    check("post_drain_skid_full", {31'b0, skid_full}, 32'd0);
    check("post_drain_skid_count", {28'b0, skid_count}, 32'd1);
    #1;

    // Saturating counter and clear priority.
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    check("clr_skid_count", {28'b0, skid_count}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      bus_if.out_ready = 1'b0;
      send(32'h100 + 32'(k));
      bus_if.out_ready = 1'b1;
      tick();
      if (k == 13) check("count_14", {28'b0, skid_count}, 32'd14);
    end
    check("count_saturated", {28'b0, skid_count}, 32'd15);
    bus_if.out_ready = 1'b0;
    clr_count        = 1'b1;
    send(32'h55);
    clr_count = 1'b0;
    check("clr_vs_capture_count", {28'b0, skid_count}, 32'd0);
    check("clr_vs_capture_full", {31'b0, skid_full}, 32'd1);
    bus_if.out_ready = 1'b1;
    tick();
    check("clr_after_drain", {28'b0, skid_count}, 32'd0);

    // Asynchronous reset while the skid holds 0x22: the beat is discarded.
    bus_if.out_ready = 1'b0;
    send(32'h22);
    check("pre_rst_full", {31'b0, skid_full}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_out_valid", {31'b0, bus_if.out_valid}, 32'd0);
    check("async_skid_full", {31'b0, skid_full}, 32'd0);
    check("async_in_ready", {31'b0, bus_if.in_ready}, 32'd0);
    exp_q.delete();
    tick();
    rst_n            = 1'b1;
    bus_if.out_ready = 1'b1;
    tick();
    send(32'h33);
    tick();

    // Random valid/ready traffic.
    chk_en = 1'b1;
    fork
      begin
        for (int n = 0; n < 10000; n++) begin
          if ($urandom_range(0, 3) == 0) tick();
          send($urandom());
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          tick();
          bus_if.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    chk_en           = 1'b0;
    bus_if.out_ready = 1'b1;
    repeat (5) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
